if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter ICACHE_INDEX_W, default 7, icache index width (2^7 = 128 lines); used only with ICACHE_EN.
REQ-002 SHALL have parameter PC_RESET, default 32'h0, first fetch address.
REQ-003 SHALL have port clk_in  input  1  the single clock, rising edge.
REQ-004 SHALL have port rst_in  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port rdy_in  input  1  global enable; when 0, all state and outputs hold.
REQ-006 SHALL have port stall_in  input  6  stall vector; bit 0 is the IF stall.
REQ-007 SHALL have port branch_or_not  input  1  EX redirect request.
REQ-008 SHALL have port branch_addr  input  32  EX redirect target.
REQ-009 SHALL have port mem_req  output  1  memory-controller fetch request.
REQ-010 SHALL have port mem_addr  output  32  fetch address.
REQ-011 SHALL have port mem_ready  input  1  one-cycle pulse; fetched word is valid.
REQ-012 SHALL have port mem_data  input  32  fetched instruction word.
REQ-013 SHALL have port if_stall_req  output  1  stall request to stall control.
REQ-014 SHALL have port output_pc  output  32  PC to IF_ID.
REQ-015 SHALL have port output_instru  output  32  instruction to IF_ID; 0 means bubble.

Function
REQ-016 SHALL implement states IDLE, WAIT_MEM and HOLD.
REQ-017 SHALL, in IDLE with stall_in[0]=0 and no branch, assert mem_req=1 with mem_addr=pc combinationally and enter WAIT_MEM at the next edge.
REQ-018 SHALL keep mem_req=1 and mem_addr stable throughout WAIT_MEM.
REQ-019 SHALL drive if_stall_req=1 in WAIT_MEM and 0 in all other states.
REQ-020 SHALL, on mem_ready in WAIT_MEM with stall_in[0]=0, register output_pc=pc and output_instru=mem_data, set pc<=pc+4 (mod 2^32) and enter IDLE; outputs are valid the cycle after mem_ready.
REQ-021 SHALL, on mem_ready in WAIT_MEM with stall_in[0]=1, capture the word in a hold buffer, enter HOLD and leave pc unchanged.
REQ-022 SHALL, in HOLD with stall_in[0]=0, present the buffered word on output_pc/output_instru, set pc<=pc+4 and enter IDLE.
REQ-023 SHALL drive output_pc=0 and output_instru=0 in every cycle where no instruction is delivered.
REQ-024 SHALL give branch_or_not priority over stall and memory events in every state: pc<=branch_addr, outputs forced to 0.
REQ-025 SHALL, on branch in WAIT_MEM, set a discard flag and stay in WAIT_MEM; the next mem_ready is dropped (outputs 0) and the state becomes IDLE.
REQ-026 SHALL, on branch in HOLD, drop the hold buffer and enter IDLE.
REQ-027 SHALL, if branch and mem_ready coincide in WAIT_MEM, drop the word, load pc<=branch_addr and enter IDLE.
REQ-028 SHALL never issue a second mem_req before the outstanding mem_ready.

Reset
REQ-029 SHALL, with rst_in=1 at a rising edge (regardless of rdy_in), set pc=PC_RESET, state=IDLE, discard=0, output_pc=0 and output_instru=0.
REQ-030 SHALL abandon any outstanding request on reset; a mem_ready arriving after reset, outside WAIT_MEM, is ignored.

Configuration
REQ-031 SHALL, with macro IF_FETCH_ICACHE_EN defined, include a direct-mapped icache: index pc[ICACHE_INDEX_W+1:2], tag pc[17:ICACHE_INDEX_W+2], one valid bit per line.
REQ-032 SHALL, on a hit in IDLE (stall_in[0]=0, no branch), deliver the cached word at the next edge with no mem_req, and set pc<=pc+4.
REQ-033 SHALL fill the addressed line on every accepted mem_ready whose word is not discarded, and clear all valid bits on reset.
REQ-034 SHALL, without IF_FETCH_ICACHE_EN, contain no cache storage and fetch every instruction from memory.

Structure
REQ-035 SHALL take the state enum, the NOP value (32'h0) and the stall-bit index constants from the shared package cpu_defs_pkg.
REQ-036 SHALL place the icache in sub-module if_icache, instantiated only under IF_FETCH_ICACHE_EN.

Verification
REQ-037 SHALL cover: reset, then mem_ready with data 32'h00000013 three cycles after mem_req -> output_pc=0, output_instru=32'h13 in the next cycle, then mem_addr=4.
REQ-038 SHALL cover: stall_in[0]=1 at mem_ready (data 32'h00A00093), released 2 cycles later -> word delivered on release, pc stays 0 until delivery.
REQ-039 SHALL cover: branch_or_not=1 with branch_addr=32'h100 in WAIT_MEM -> the next mem_ready is dropped (outputs 0), then mem_addr=32'h100.
REQ-040 SHALL cover: branch coinciding with mem_ready -> no delivery, next mem_addr=branch_addr.
REQ-041 SHALL cover: rdy_in=0 for 4 cycles mid-WAIT_MEM -> all state frozen; rst_in=1 mid-WAIT_MEM -> outputs 0 and mem_addr=PC_RESET.
REQ-042 SHALL cover, with IF_FETCH_ICACHE_EN: a loop jumping back to 32'h8 -> the second pass issues no mem_req and delivers each instruction one cycle after IDLE.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM states, bubble encoding and stall-vector bit positions.
package cpu_defs_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    HOLD     = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP = 32'h0;

  localparam int STALL_W   = 6;
  localparam int STALL_IF  = 0;
  localparam int STALL_ID  = 1;
  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;
  localparam int STALL_WB  = 4;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-fetch memory bus: one outstanding request, mem_ready is a single-cycle data strobe.
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport master (output mem_req, mem_addr, input mem_ready, mem_data);
  modport slave  (input mem_req, mem_addr, output mem_ready, mem_data);
endinterface

// File: rtl/if_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-cycle fill.
// Valid bits clear on reset; tag/data arrays are not reset.
module if_icache
  import cpu_defs_pkg::*;
#(
  parameter int INDEX_W = 7
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] lookup_addr,
  output logic        hit,
  output logic [31:0] hit_data,
  input  logic        fill_en,
  input  logic [31:0] fill_addr,
  input  logic [31:0] fill_data
);
  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 18 - (INDEX_W + 2);

  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [INDEX_W-1:0] l_idx, f_idx;
  logic [TAG_W-1:0]   l_tag, f_tag;

  assign l_idx = lookup_addr[INDEX_W+1:2];
  assign l_tag = lookup_addr[17:INDEX_W+2];
  assign f_idx = fill_addr[INDEX_W+1:2];
  assign f_tag = fill_addr[17:INDEX_W+2];

  assign hit      = valid[l_idx] && (tag_mem[l_idx] == l_tag);
  assign hit_data = hit ? data_mem[l_idx] : NOP;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[f_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[f_idx]  <= f_tag;
      data_mem[f_idx] <= fill_data;
    end
  end

  // Byte-offset and above-tag address bits do not take part in lookup.
  logic unused_bits;
  assign unused_bits = ^{lookup_addr[31:18], lookup_addr[1:0], fill_addr[31:18], fill_addr[1:0]};

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding memory fetch, stall hold buffer, EX redirect with discard.
// Optional direct-mapped icache under IF_FETCH_ICACHE_EN; outputs registered, 0 marks a bubble.
module if_fetch
  import cpu_defs_pkg::*;
#(
  parameter int          ICACHE_INDEX_W = 7,
  parameter logic [31:0] PC_RESET       = 32'h0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [5:0]        stall_in,
  input  logic              branch_or_not,
  input  logic [31:0]       branch_addr,
  if_fetch_if.master        mem,
  output logic              if_stall_req,
  output logic [31:0]       output_pc,
  output logic [31:0]       output_instru
);
  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  req_addr;
  logic [31:0]  hold_instru;
  logic         discard;

  logic         stall_if;
  logic         hit;
  logic [31:0]  hit_data;
  logic         fill_en;
  logic         issue;

  assign stall_if = stall_in[STALL_IF];

  assign issue        = rdy_in && (state == IDLE) && !stall_if && !branch_or_not && !hit;
  assign mem.mem_req  = (state == WAIT_MEM) || issue;
  // A redirect during WAIT_MEM moves pc, so the in-flight address is held separately.
  assign mem.mem_addr = (state == WAIT_MEM) ? req_addr : pc;
  assign if_stall_req = (state == WAIT_MEM);

  assign fill_en = rdy_in && !rst_in && (state == WAIT_MEM) && mem.mem_ready
                   && !branch_or_not && !discard;

`ifdef IF_FETCH_ICACHE_EN
  if_icache #(.INDEX_W(ICACHE_INDEX_W)) u_icache (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .lookup_addr (pc),
    .hit         (hit),
    .hit_data    (hit_data),
    .fill_en     (fill_en),
    .fill_addr   (req_addr),
    .fill_data   (mem.mem_data)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = NOP;
  logic unused_cache;
  assign unused_cache = ^{fill_en, ICACHE_INDEX_W};
`endif

  logic unused_stall;
  assign unused_stall = ^stall_in[5:1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      pc            <= PC_RESET;
      req_addr      <= PC_RESET;
      hold_instru   <= NOP;
      discard       <= 1'b0;
      output_pc     <= '0;
      output_instru <= NOP;
    end else if (rdy_in) begin
      output_pc     <= '0;
      output_instru <= NOP;
      case (state)
        IDLE: begin
          if (branch_or_not) begin
            pc <= branch_addr;
          end else if (!stall_if) begin
            if (hit) begin
              output_pc     <= pc;
              output_instru <= hit_data;
              pc            <= next_pc(pc);
            end else begin
              req_addr <= pc;
              state    <= WAIT_MEM;
            end
          end
        end
        WAIT_MEM: begin
          if (branch_or_not) begin
            pc <= branch_addr;
            if (mem.mem_ready) begin
              state   <= IDLE;
              discard <= 1'b0;
            end else begin
              discard <= 1'b1;
            end
          end else if (mem.mem_ready) begin
            if (discard) begin
              discard <= 1'b0;
              state   <= IDLE;
            end else if (stall_if) begin
              hold_instru <= mem.mem_data;
              state       <= HOLD;
            end else begin
              output_pc     <= pc;
              output_instru <= mem.mem_data;
              pc            <= next_pc(pc);
              state         <= IDLE;
            end
          end
        end
        HOLD: begin
          if (branch_or_not) begin
            pc    <= branch_addr;
            state <= IDLE;
          end else if (!stall_if) begin
            output_pc     <= pc;
            output_instru <= hold_instru;
            pc            <= next_pc(pc);
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
